// File: rtl/mant_mul_pkg.sv
// Shared types and constants for the sequential mantissa multiplier.
package mant_mul_pkg;

  localparam int unsigned DIG_W = 6;
  localparam int unsigned PP_W  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Weight of a digit-pair partial product inside the accumulator.
  function automatic int unsigned dig_shift(input int unsigned i, input int unsigned j);
    return DIG_W * (i + j);
  endfunction

endpackage

// File: rtl/vedic6.sv
// 6x6 unsigned multiplier built from four 3x3 vertical/crosswise products.
module vedic6 (
  input  logic [5:0]  i_a,
  input  logic [5:0]  i_b,
  output logic [11:0] o_p_c
);

  logic [5:0] w_ll;
  logic [5:0] w_lh;
  logic [5:0] w_hl;
  logic [5:0] w_hh;

  assign w_ll = 6'(i_a[2:0]) * 6'(i_b[2:0]);
  assign w_lh = 6'(i_a[2:0]) * 6'(i_b[5:3]);
  assign w_hl = 6'(i_a[5:3]) * 6'(i_b[2:0]);
  assign w_hh = 6'(i_a[5:3]) * 6'(i_b[5:3]);

  assign o_p_c = (12'(w_hh) << 6) + ((12'(w_hl) + 12'(w_lh)) << 3) + 12'(w_ll);

endmodule

// File: rtl/mant_mul_seq.sv
// Multi-cycle WIDTH x WIDTH mantissa multiplier sharing one vedic6 across digit pairs.
// Optional MANT_MUL_ZERO_SKIP_EN: zero operands bypass RUN and complete immediately.
module mant_mul_seq
  import mant_mul_pkg::*;
#(
  parameter  int unsigned NDIG  = 4,
  localparam int unsigned WIDTH = DIG_W * NDIG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned ACC_W  = 2 * WIDTH;
  localparam int unsigned NSTEP  = NDIG * NDIG;
  localparam int unsigned STEP_W = $clog2(NSTEP + 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [STEP_W-1:0]    r_step;
  logic [ACC_W-1:0]     r_acc;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic                 w_accept;
  logic                 w_last;
  int unsigned          w_i;
  int unsigned          w_j;
  logic [DIG_W-1:0]     w_dig_a;
  logic [DIG_W-1:0]     w_dig_b;
  logic [PP_W-1:0]      w_pp;

  // Digit selection: j (digit of b) is the inner loop.
  always_comb begin
    w_i     = 32'(r_step) / NDIG;
    w_j     = 32'(r_step) % NDIG;
    w_dig_a = DIG_W'(r_a >> (DIG_W * w_i));
    w_dig_b = DIG_W'(r_b >> (DIG_W * w_j));
  end

  vedic6 u_vedic6 (
    .i_a   (w_dig_a),
    .i_b   (w_dig_b),
    .o_p_c (w_pp)
  );

  assign w_last = (r_step == STEP_W'(NSTEP - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
`ifdef MANT_MUL_ZERO_SKIP_EN
          w_state_nxt = ((a == '0) || (b == '0)) ? DONE : RUN;
`else
          w_state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt == RUN);
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_acc  <= '0;
        r_step <= '0;
      end else if (r_state == RUN) begin
        r_acc  <= r_acc + (ACC_W'(w_pp) << dig_shift(w_i, w_j));
        r_step <= w_last ? '0 : r_step + STEP_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign p         = r_acc;

endmodule
